// File: rtl/nco_core.sv
// -----------------------------------------------------------------------------
// nco_core
//   Multi-channel numerically controlled oscillator.  Every channel owns a
//   phase accumulator and a tuning word.  The top TBL_AW bits of each
//   accumulator address a shared, run-time writable sine table, and the table
//   word comes back as that channel's sample.
//
//   Pipeline (edge N = accumulator update):
//     edge N   : acc_p0 steps, preloads, or holds
//     edge N+1 : cphase <= table index of acc_p0, table word read into rd_p1
//     edge N+2 : cout <= rd_p1
//   cvalid follows (enable | preload) through the same three registers, so it
//   marks the cout that was derived from an accumulator step or preload.
//
// Ports
//   clk        sole clock, rising edge
//   reset      asynchronous, active-high; clears accumulators, tuning words
//              (to 1), cphase, cout and cvalid.  The table is not cleared.
//   enable     advance all accumulators by their tuning word
//   updn       1 = add tuning word, 0 = subtract (modulo 2^ACC_W)
//   preload    load pl_data into the accumulator of channel pl_ch
//   pl_ch      preload channel select (values >= NCH are ignored)
//   pl_data    preload phase value
//   cfg_we     write cfg_incr into the tuning word of channel cfg_ch
//   cfg_ch     tuning-word channel select (values >= NCH are ignored)
//   cfg_incr   new tuning word
//   tbl_we     table write strobe
//   tbl_addr   table write address
//   tbl_wmask  per-byte write enable, bit k covers bits 8k+7:8k
//   tbl_din    table write data
//   cphase     per-channel table index, channel c at [c*TBL_AW +: TBL_AW]
//   cout       per-channel sample, channel c at [c*DATA_W +: DATA_W]
//   cvalid     cout holds a sample from a completed accumulator step
// -----------------------------------------------------------------------------
module nco_core #(
  parameter int ACC_W  = 16,
  parameter int TBL_AW = 8,
  parameter int DATA_W = 32,
  parameter int NCH    = 2,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int MASK_W = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     updn,
  input  logic                     preload,
  input  logic [CH_W-1:0]          pl_ch,
  input  logic [ACC_W-1:0]         pl_data,
  input  logic                     cfg_we,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [ACC_W-1:0]         cfg_incr,
  input  logic                     tbl_we,
  input  logic [TBL_AW-1:0]        tbl_addr,
  input  logic [MASK_W-1:0]        tbl_wmask,
  input  logic [DATA_W-1:0]        tbl_din,
  output logic [NCH*TBL_AW-1:0]    cphase,
  output logic [NCH*DATA_W-1:0]    cout,
  output logic                     cvalid
);

  localparam int TBL_N = 1 << TBL_AW;

  logic [ACC_W-1:0]  acc_p0  [NCH];
  logic [ACC_W-1:0]  incr    [NCH];
  logic              vld_p0;
  logic [DATA_W-1:0] rd_p1   [NCH];
  logic              vld_p1;
  logic [DATA_W-1:0] tbl_mem [TBL_N];

  // Modular phase step; the sum/difference simply wraps at 2^ACC_W.
  function automatic logic [ACC_W-1:0] step_phase(
    input logic [ACC_W-1:0] acc,
    input logic [ACC_W-1:0] inc,
    input logic             up
  );
    logic [ACC_W-1:0] res;
    if (up) res = acc + inc;
    else    res = acc - inc;
    return res;
  endfunction

  // Table index is the top TBL_AW bits of the accumulator.
  function automatic logic [TBL_AW-1:0] tbl_index(input logic [ACC_W-1:0] acc);
    return acc[ACC_W-1 -: TBL_AW];
  endfunction

  // ---- stage 0: accumulator and tuning-word update ----
  // A preload wins over the step for its own channel only.  A tuning-word
  // write lands at this edge, so the step taken at the same edge still uses
  // the previous tuning word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        acc_p0[c] <= '0;
        incr[c]   <= ACC_W'(1);
      end
    end else begin
      vld_p0 <= enable | preload;
      for (int c = 0; c < NCH; c++) begin
        if (cfg_we && (cfg_ch == CH_W'(c)))
          incr[c] <= cfg_incr;
        if (preload && (pl_ch == CH_W'(c)))
          acc_p0[c] <= pl_data;
        else if (enable)
          acc_p0[c] <= step_phase(acc_p0[c], incr[c], updn);
      end
    end
  end

  // ---- stage 1: sine table (masked write port, NCH registered read ports) ----
  // Reads and the write share one nonblocking block, so a read of the address
  // being written at the same edge returns the previous word.  The table and
  // its read registers carry no reset so the storage can map onto RAM.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      for (int k = 0; k < MASK_W; k++) begin
        if (tbl_wmask[k])
          tbl_mem[tbl_addr][8*k +: 8] <= tbl_din[8*k +: 8];
      end
    end
    for (int c = 0; c < NCH; c++)
      rd_p1[c] <= tbl_mem[tbl_index(acc_p0[c])];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cphase <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      for (int c = 0; c < NCH; c++)
        cphase[c*TBL_AW +: TBL_AW] <= tbl_index(acc_p0[c]);
    end
  end

  // ---- stage 2: sample output ----
  // cout keeps re-reading the table even while cvalid is low, so a table
  // write at a held index still shows up on cout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cout   <= '0;
      cvalid <= 1'b0;
    end else begin
      cvalid <= vld_p1;
      for (int c = 0; c < NCH; c++)
        cout[c*DATA_W +: DATA_W] <= rd_p1[c];
    end
  end

endmodule

// File: tb/tb_nco_core.sv
module tb_nco_core;

  localparam int ACC_W  = 16;
  localparam int TBL_AW = 8;
  localparam int DATA_W = 32;
  localparam int NCH    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        updn = 1'b1;
  logic        preload = 1'b0;
  logic [0:0]  pl_ch = '0;
  logic [15:0] pl_data = '0;
  logic        cfg_we = 1'b0;
  logic [0:0]  cfg_ch = '0;
  logic [15:0] cfg_incr = '0;
  logic        tbl_we = 1'b0;
  logic [7:0]  tbl_addr = '0;
  logic [3:0]  tbl_wmask = '0;
  logic [31:0] tbl_din = '0;
  logic [15:0] cphase;
  logic [63:0] cout;
  logic        cvalid;

  nco_core #(.ACC_W(ACC_W), .TBL_AW(TBL_AW), .DATA_W(DATA_W), .NCH(NCH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .updn(updn),
    .preload(preload), .pl_ch(pl_ch), .pl_data(pl_data),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_incr(cfg_incr),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wmask(tbl_wmask), .tbl_din(tbl_din),
    .cphase(cphase), .cout(cout), .cvalid(cvalid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: expected {ch1, ch0} sample per valid-producing cycle.
  logic [63:0] sb_q[$];
  int          tag_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input logic [31:0] c0, input logic [31:0] c1, input int tag);
    sb_q.push_back({c1, c0});
    tag_q.push_back(tag);
  endtask

  // One clock cycle of control stimulus, applied at the falling edge.
  task automatic cyc(input logic en, input logic ud, input logic pl, input logic plch,
                     input logic [15:0] pld, input logic cw, input logic cch,
                     input logic [15:0] cinc);
    @(negedge clk);
    enable = en; updn = ud; preload = pl; pl_ch = plch; pl_data = pld;
    cfg_we = cw; cfg_ch = cch; cfg_incr = cinc;
    tbl_we = 1'b0; tbl_addr = '0; tbl_wmask = '0; tbl_din = '0;
  endtask

  task automatic twrite(input logic [7:0] a, input logic [3:0] m, input logic [31:0] d);
    tbl_we = 1'b1; tbl_addr = a; tbl_wmask = m; tbl_din = d;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic step(input logic ud);
    cyc(1'b1, ud, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic pre(input logic ch, input logic [15:0] d);
    cyc(1'b0, 1'b1, 1'b1, ch, d, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic cfg(input logic ch, input logic [15:0] inc);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, ch, inc);
  endtask

  // Monitor: every valid sample must match the oldest expected entry.
  always @(negedge clk) begin
    logic [63:0] e;
    int          t;
    if (!reset && cvalid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_sample: got cout %h, expected no valid sample", cout);
      end else begin
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        check($sformatf("sample_%0d", t), cout, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] b_c0 [5];
    logic [31:0] b_c1 [5];
    int          waited;
    b_c0 = '{32'h20, 32'h50, 32'h80, 32'hB0, 32'hE0};
    b_c1 = '{32'h00, 32'h10, 32'h10, 32'h20, 32'h20};

    // Reset takes effect without a clock edge
    #2 reset = 1'b1;
    #1;
    check("rst_cout",   cout, 64'h0);
    check("rst_cphase", {48'h0, cphase}, 64'h0);
    check("rst_cvalid", {63'h0, cvalid}, 64'h0);
    @(negedge clk) reset = 1'b0;

    // Table entry i = i*16
    for (int i = 0; i < 256; i++) begin
      idle();
      twrite(8'(i), 4'hF, 32'(i * 16));
    end
    idle();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;

    // ch0 incr 0x0100: one table step per cycle, ch1 (incr 1) stays at index 0
    cfg(1'b0, 16'h0100);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1);
      expect_out(32'(16 * k), 32'h0, k);
      if (k == 3) check("cvalid_after_edge2", {63'h0, cvalid}, 64'h0);
      if (k == 4) check("cvalid_after_edge3", {63'h0, cvalid}, 64'h1);
    end

    // ch1 incr 0x0080, ch0 incr 0x0300 from 0xFF00 (wraps to 0x0200)
    cfg(1'b1, 16'h0080);
    cfg(1'b0, 16'h0300);
    pre(1'b0, 16'hFF00);
    expect_out(32'hFF0, 32'h0, 100);
    for (int k = 0; k < 5; k++) begin
      step(1'b1);
      expect_out(b_c0[k], b_c1[k], 101 + k);
    end

    // Down-counting from 0, then preload ch1 with enable low
    cfg(1'b0, 16'h0100);
    pre(1'b0, 16'h0000);
    expect_out(32'h0, 32'h20, 200);
    step(1'b0);
    expect_out(32'hFF0, 32'h20, 201);
    step(1'b0);
    expect_out(32'hFE0, 32'h10, 202);
    pre(1'b1, 16'h0500);
    expect_out(32'hFE0, 32'h50, 203);

    // Masked write at ch1's held index: same-edge read sees old word
    pre(1'b1, 16'h0500);
    expect_out(32'hFE0, 32'h50, 300);
    pre(1'b1, 16'h0500);
    twrite(8'h05, 4'b0010, 32'hAAAA_BBBB);
    expect_out(32'hFE0, 32'h0000_BB50, 301);
    pre(1'b1, 16'h0500);
    expect_out(32'hFE0, 32'h0000_BB50, 302);
    for (int k = 0; k < 4; k++) idle();
    check("hold_cout",   cout, {32'h0000_BB50, 32'h0000_0FE0});
    check("hold_cphase", {48'h0, cphase}, {48'h0, 8'h05, 8'hFE});
    check("hold_cvalid", {63'h0, cvalid}, 64'h0);

    // Write at a held index with no valid traffic reaches cout two edges later
    idle();
    twrite(8'hFE, 4'b0001, 32'h0000_0077);
    idle();
    idle();
    check("idle_write_old", {32'h0, cout[31:0]}, 64'h0FE0);
    idle();
    check("idle_write_new", {32'h0, cout[31:0]}, 64'h0F77);

    // Sweep, then reset mid-flight
    step(1'b1);
    expect_out(32'hFF0, 32'h0000_BB50, 400);
    step(1'b1);
    expect_out(32'h0, 32'h60, 401);
    step(1'b1);
    expect_out(32'h10, 32'h60, 402);
    step(1'b1);
    expect_out(32'h20, 32'h70, 403);
    @(posedge clk);
    #3 reset = 1'b1;
    sb_q.delete();
    tag_q.delete();
    #1;
    check("midrst_cout",   cout, 64'h0);
    check("midrst_cphase", {48'h0, cphase}, 64'h0);
    check("midrst_cvalid", {63'h0, cvalid}, 64'h0);
    idle();
    idle();
    reset = 1'b0;

    // After release: incr back to 1 in both channels, table intact
    pre(1'b0, 16'h0101);
    expect_out(32'h10, 32'h0, 500);
    pre(1'b1, 16'h0101);
    expect_out(32'h10, 32'h10, 501);
    step(1'b0);
    expect_out(32'h10, 32'h10, 502);
    check("postrst_cvalid_edge2", {63'h0, cvalid}, 64'h0);
    step(1'b0);
    expect_out(32'h0, 32'h0, 503);
    step(1'b0);
    expect_out(32'h0, 32'h0, 504);

    // Drain with a bounded wait
    waited = 0;
    while (sb_q.size() != 0 && waited < 20) begin
      idle();
      waited++;
    end
    idle();
    idle();
    check("scoreboard_drained", 64'(sb_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
